// File: rtl/ball_pixel_source.sv
// Per-pixel filled-circle renderer with a 3-stage distance pipeline.
// Ball parameters arrive through a valid/ready shadow and go live only at frame start.
module ball_pixel_source #(
   parameter int unsigned H_ACTIVE = 1600,
   parameter int unsigned V_ACTIVE = 1200,
   parameter int unsigned COORD_W  = 11,
   parameter int unsigned RAD_W    = 8,
   parameter logic [11:0] BG_COLOR = 12'h000
) (
   input  logic               clock_162,
   input  logic               rst,
   input  logic [COORD_W-1:0] pix_col,
   input  logic [COORD_W-1:0] pix_row,
   input  logic               pix_active,
   input  logic               frame_start,
   input  logic               upd_valid,
   output logic               upd_ready,
   input  logic [COORD_W-1:0] upd_x,
   input  logic [COORD_W-1:0] upd_y,
   input  logic [RAD_W-1:0]   upd_r,
   input  logic [11:0]        upd_color,
   output logic [3:0]         red,
   output logic [3:0]         green,
   output logic [3:0]         blue,
   output logic               out_active
);

   localparam int unsigned DIFF_W = COORD_W + 1;
   localparam int unsigned SQ_W   = 2 * COORD_W;
   localparam int unsigned SUM_W  = SQ_W + 1;
   localparam int unsigned R2_W   = 2 * RAD_W;

   localparam logic [COORD_W-1:0] RST_X     = COORD_W'(H_ACTIVE / 2);
   localparam logic [COORD_W-1:0] RST_Y     = COORD_W'(V_ACTIVE / 2);
   localparam logic [11:0]        RST_COLOR = 12'hFFF;

   logic [COORD_W-1:0] r_shd_x, r_shd_y;
   logic [RAD_W-1:0]   r_shd_r;
   logic [11:0]        r_shd_color;
   logic               r_pending;

   logic [COORD_W-1:0] r_act_x, r_act_y;
   logic [RAD_W-1:0]   r_act_r;
   logic [11:0]        r_act_color;

   logic [DIFF_W-1:0]  r_s1_dx, r_s1_dy;
   logic [RAD_W-1:0]   r_s1_r;
   logic [11:0]        r_s1_color;
   logic               r_s1_active;

   logic [SQ_W-1:0]    r_s2_dx2, r_s2_dy2;
   logic [R2_W-1:0]    r_s2_r2;
   logic [11:0]        r_s2_color;
   logic               r_s2_active;

   logic [11:0]        r_rgb;
   logic               r_out_active;

   logic               w_xfer;
   logic               w_commit;
   logic [DIFF_W-1:0]  w_dx, w_dy;
   logic [COORD_W-1:0] w_adx, w_ady;
   logic [SUM_W-1:0]   w_sum;
   logic               w_inside;
   logic [11:0]        w_pix;

   assign upd_ready = !r_pending;
   assign w_xfer    = upd_valid && !r_pending;
   assign w_commit  = frame_start && r_pending;

   // Shadow capture and pending flag; a commit always wins over a new transfer
   always_ff @(posedge clock_162 or negedge rst) begin
      if (!rst) begin
         r_shd_x     <= RST_X;
         r_shd_y     <= RST_Y;
         r_shd_r     <= '0;
         r_shd_color <= RST_COLOR;
         r_pending   <= 1'b0;
      end else if (w_commit) begin
         r_pending   <= 1'b0;
      end else if (w_xfer) begin
         r_shd_x     <= upd_x;
         r_shd_y     <= upd_y;
         r_shd_r     <= upd_r;
         r_shd_color <= upd_color;
         r_pending   <= 1'b1;
      end
   end

   always_ff @(posedge clock_162 or negedge rst) begin
      if (!rst) begin
         r_act_x     <= RST_X;
         r_act_y     <= RST_Y;
         r_act_r     <= '0;
         r_act_color <= RST_COLOR;
      end else if (w_commit) begin
         r_act_x     <= r_shd_x;
         r_act_y     <= r_shd_y;
         r_act_r     <= r_shd_r;
         r_act_color <= r_shd_color;
      end
   end

   // One extra bit keeps the signed difference from wrapping at the coordinate limits
   assign w_dx = DIFF_W'(pix_col) - DIFF_W'(r_act_x);
   assign w_dy = DIFF_W'(pix_row) - DIFF_W'(r_act_y);

   always_ff @(posedge clock_162 or negedge rst) begin
      if (!rst) begin
         r_s1_dx     <= '0;
         r_s1_dy     <= '0;
         r_s1_r      <= '0;
         r_s1_color  <= '0;
         r_s1_active <= 1'b0;
      end else begin
         r_s1_dx     <= w_dx;
         r_s1_dy     <= w_dy;
         r_s1_r      <= r_act_r;
         r_s1_color  <= r_act_color;
         r_s1_active <= pix_active;
      end
   end

   // Magnitude always fits in COORD_W bits, so squaring it unsigned is exact
   assign w_adx = r_s1_dx[DIFF_W-1] ? COORD_W'(-r_s1_dx) : COORD_W'(r_s1_dx);
   assign w_ady = r_s1_dy[DIFF_W-1] ? COORD_W'(-r_s1_dy) : COORD_W'(r_s1_dy);

   always_ff @(posedge clock_162 or negedge rst) begin
      if (!rst) begin
         r_s2_dx2    <= '0;
         r_s2_dy2    <= '0;
         r_s2_r2     <= '0;
         r_s2_color  <= '0;
         r_s2_active <= 1'b0;
      end else begin
         r_s2_dx2    <= SQ_W'(w_adx) * SQ_W'(w_adx);
         r_s2_dy2    <= SQ_W'(w_ady) * SQ_W'(w_ady);
         r_s2_r2     <= R2_W'(r_s1_r) * R2_W'(r_s1_r);
         r_s2_color  <= r_s1_color;
         r_s2_active <= r_s1_active;
      end
   end

   assign w_sum    = SUM_W'(r_s2_dx2) + SUM_W'(r_s2_dy2);
   assign w_inside = (w_sum <= SUM_W'(r_s2_r2));

   always_comb begin
      w_pix = 12'h000;
      if (r_s2_active) begin
         w_pix = w_inside ? r_s2_color : BG_COLOR;
      end
   end

   always_ff @(posedge clock_162 or negedge rst) begin
      if (!rst) begin
         r_rgb        <= 12'h000;
         r_out_active <= 1'b0;
      end else begin
         r_rgb        <= w_pix;
         r_out_active <= r_s2_active;
      end
   end

   assign red        = r_rgb[11:8];
   assign green      = r_rgb[7:4];
   assign blue       = r_rgb[3:0];
   assign out_active = r_out_active;

endmodule

// File: doc/ball_pixel_source.md
Name: ball_pixel_source

Overview:
- Pixel-colour generator directly upstream of VGA_driver in the 1600x1200@60 (162 MHz) display path.
- Takes the current beam position and frame-start strobe from the timing logic.
- Decides per pixel whether it falls inside the simulated ball (filled circle), and returns 12-bit RGB after a fixed 3-cycle pipeline.
- The physics engine posts new ball parameters through a valid/ready handshake; they are applied only at frame start, so no tearing.

Parameters:
- H_ACTIVE, 1600, active pixels per line
- V_ACTIVE, 1200, active lines per frame
- COORD_W, 11, width of pixel/ball coordinates
- RAD_W, 8, width of ball radius
- BG_COLOR, 12'h000, {R,G,B} background colour inside active video

Ports:
- clock_162  in  1  162 MHz pixel clock
- rst  in  1  asynchronous, active-low reset
- pix_col  in  COORD_W  current beam column
- pix_row  in  COORD_W  current beam row
- pix_active  in  1  beam is in the active region
- frame_start  in  1  one-cycle pulse at the start of each frame (first vblank cycle)
- upd_valid  in  1  physics engine offers new ball parameters
- upd_ready  out  1  block can accept an update
- upd_x  in  COORD_W  ball centre column
- upd_y  in  COORD_W  ball centre row
- upd_r  in  RAD_W  ball radius
- upd_color  in  12  ball colour {R[3:0],G[3:0],B[3:0]}
- red, green, blue  out  4 each  pixel colour for VGA_driver
- out_active  out  1  pix_active delayed to align with the colour outputs

Behaviour:
- Reset (rst low, async): red/green/blue=0, out_active=0, upd_ready=1, shadow pending=0.
- Reset values of the active ball registers: x=H_ACTIVE/2, y=V_ACTIVE/2, r=0, color=12'hFFF. Shadow registers reset to the same values.
- Update handshake:
  - Transfer occurs when upd_valid && upd_ready on a rising edge.
  - The transfer captures upd_x/y/r/color into the shadow registers and sets pending=1.
  - upd_ready = !pending, combinational from the pending register.
  - upd_valid held with upd_ready=0 causes no capture; the upstream must hold its data.
- Frame commit: on a frame_start cycle with pending=1, shadow is copied to the active registers and pending clears. upd_ready rises on the next cycle.
- Simultaneous frame_start and transfer (only possible with pending=0): the shadow captures the new data and pending sets. The active registers are unchanged; the new data commits at the next frame_start.
- frame_start with pending=0: no change.
- Active registers never change except at frame_start or reset.
- Pipeline, 3 cycles; all stages advance every cycle, with no stall.
  - S1: dx = pix_col - x, dy = pix_row - y, signed COORD_W+1 bits. r, color and pix_active are registered alongside.
  - S2: dx2 = dx*dx, dy2 = dy*dy, unsigned 2*COORD_W bits; r2 = r*r, 2*RAD_W bits.
  - S3: inside = (dx2 + dy2) <= r2, with the sum computed in 2*COORD_W+1 bits and no truncation.
  - S3 outputs:
    - {red,green,blue} = inside ? color : BG_COLOR when the delayed pix_active=1.
    - {red,green,blue} = 12'h000 when the delayed pix_active=0 (blanking must be black).
    - out_active = pix_active delayed by 3 cycles.
- Ball parameters used for a pixel are those active when that pixel entered S1. A commit mid-pipeline affects only later pixels.
- r=0 draws exactly one pixel at (x,y). Parts of the ball off-screen or beyond coordinate limits are simply not drawn; no wrap-around of dx/dy, because signed subtraction is one bit wider.
- Reset mid-frame: the pipeline is flushed to black/out_active=0 immediately; normal output resumes 3 cycles after rst deasserts.

Test Plan:
- Reset release, pix_active=1 at (800,600), no update → white (F,F,F) exactly 3 cycles later. (799,600) and (800,601) → black via BG_COLOR=0.
- Update x=100,y=100,r=10,color=12'hF00 mid-frame → upd_ready falls next cycle; drawing is unchanged until frame_start. Then (110,100)=F,0,0, (111,100)=0,0,0, (107,107)=F,0,0 (98≤100), (108,107)=0 (113>100). upd_ready=1 the cycle after frame_start.
- upd_valid held while pending → no second capture. The second value commits only at the frame_start after the first commit.
- Transfer in the same cycle as frame_start with pending=0 → active unchanged this frame; the new ball appears after the next frame_start.
- Ball x=0,y=0,r=255, query (0,0),(180,180),(181,180) → colour, colour (64800≤65025), background (65161>65025); pix_active=0 at any position → 0,0,0 and out_active=0.
- Assert rst low mid-frame with colour on the outputs → outputs 0 asynchronously. Active ball returns to (800,600) r=0 white, pending=0, upd_ready=1.
